// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter_pkg
// Description : Shared types for the L1-to-pmem arbiter: cache line type,
//               arbiter state encoding and requester identity.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_mem_arbiter_pkg;

  localparam int LINE_BITS   = 128;
  // Lines are 16 bytes, so the low four address bits select a byte in a line.
  localparam int OFFSET_BITS = 4;

  typedef logic [LINE_BITS-1:0] lc3b_c_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } lc3b_requester;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_sat.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//               clr has priority over inc.
// Ports       : clk, rst_n (async active-low), inc (count one event),
//               clr (synchronous clear), count (current value)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one pmem/L2 port between I-cache fills and D-cache
//               fills/writebacks. One whole-line transaction at a time,
//               round-robin on contention, saturating per-requester counters.
// Ports       : clk, rst_n (async active-low)
//               i_read/i_address -> i_resp/i_rdata      : I-cache side
//               d_read/d_write/d_address/d_wdata
//                               -> d_resp/d_rdata       : D-cache side
//               pmem_read/pmem_write/pmem_address/pmem_wdata,
//               pmem_rdata/pmem_resp                    : downstream port
//               cnt_clear -> i_xfer_count/d_xfer_count  : statistics
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  i_xfer_count,
  output logic [CNT_W-1:0]  d_xfer_count
);

  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~{{(ADDR_W-OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};

  lc3b_arb_state     state_q, state_d;
  lc3b_requester     last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              op_write_q;

  logic              d_req;
  logic              grant_i, grant_d;
  logic [ADDR_W-1:0] grant_addr;

  assign d_req      = d_read | d_write;
  assign grant_addr = grant_d ? d_address : i_address;

  // Fill data is broadcast; each cache only trusts it when its resp is high.
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;
  assign pmem_address = addr_q;

  always_comb begin
    state_d    = state_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention, D wins only if I had the previous grant.
        if (d_req && (!i_read || (last_grant_q == REQ_I))) begin
          grant_d = 1'b1;
          state_d = SERVE_D;
        end else if (i_read) begin
          grant_i = 1'b1;
          state_d = SERVE_I;
        end
      end
      SERVE_I: begin
        pmem_read  = ~op_write_q;
        pmem_write = op_write_q;
        i_resp     = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end
      SERVE_D: begin
        pmem_read  = ~op_write_q;
        pmem_write = op_write_q;
        // The D-cache holds d_wdata stable until d_resp, so no copy is kept.
        pmem_wdata = d_wdata;
        d_resp     = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
      addr_q       <= '0;
      op_write_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_i || grant_d) begin
        addr_q       <= grant_addr & LINE_MASK;
        // A writeback beats a fill when the D-cache raises both.
        op_write_q   <= grant_d & d_write;
        last_grant_q <= grant_d ? REQ_D : REQ_I;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_i_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (i_resp),
    .clr   (cnt_clear),
    .count (i_xfer_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_d_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (d_resp),
    .clr   (cnt_clear),
    .count (d_xfer_count)
  );

endmodule
`default_nettype wire
